// File: rtl/mux_scan_ctrl_if.sv
// Bus between the scan sequencer and its user: run/hold controls in,
// mux select, row enables, output enable and frame pulse out.
`timescale 1ns/1ps
interface mux_scan_ctrl_if #(
    parameter int NUM_SRC = 10
);
    logic               SC_SCANCTRL_enable_In;
    logic               SC_SCANCTRL_hold_In;
    logic [3:0]         SC_SCANCTRL_select_OutBUS;
    logic [NUM_SRC-1:0] SC_SCANCTRL_row_OutBUS;
    logic               SC_SCANCTRL_oe_Out;
    logic               SC_SCANCTRL_frameDone_Out;

    modport master (
        output SC_SCANCTRL_enable_In,
        output SC_SCANCTRL_hold_In,
        input  SC_SCANCTRL_select_OutBUS,
        input  SC_SCANCTRL_row_OutBUS,
        input  SC_SCANCTRL_oe_Out,
        input  SC_SCANCTRL_frameDone_Out
    );

    modport slave (
        input  SC_SCANCTRL_enable_In,
        input  SC_SCANCTRL_hold_In,
        output SC_SCANCTRL_select_OutBUS,
        output SC_SCANCTRL_row_OutBUS,
        output SC_SCANCTRL_oe_Out,
        output SC_SCANCTRL_frameDone_Out
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// LED-matrix row multiplexer sequencer: steps the source select with a blanked
// lead-in per slot, drives one-hot rows / output enable, pulses at frame wrap.
`timescale 1ns/1ps
module mux_scan_ctrl #(
    parameter int NUM_SRC = 10,
    parameter int DWELL   = 1000,
    parameter int BLANK   = 16,
    parameter int CNT_W   = 16
) (
    input  logic         SC_SCANCTRL_CLOCK_50,
    input  logic         SC_SCANCTRL_RESET_InLow,
    mux_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_t;

    localparam logic [3:0]       SEL_LAST   = 4'(NUM_SRC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] HOLD_CNT   = CNT_W'(BLANK);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [3:0]         sel, sel_nxt;
    logic [NUM_SRC-1:0] row, row_nxt;
    logic               oe, oe_nxt;
    logic               frame_done, frame_done_nxt;

    always_ff @(posedge SC_SCANCTRL_CLOCK_50 or negedge SC_SCANCTRL_RESET_InLow) begin
        if (!SC_SCANCTRL_RESET_InLow) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sel        <= '0;
            row        <= '0;
            oe         <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sel        <= sel_nxt;
            row        <= row_nxt;
            oe         <= oe_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        sel_nxt        = sel;
        frame_done_nxt = 1'b0;

        if (!bus.SC_SCANCTRL_enable_In) begin
            // Dropping enable wins over slot end and hold.
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            sel_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                end
                ST_BLANK: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == BLANK_LAST) begin
                        state_nxt = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (cnt != DWELL_LAST) begin
                        cnt_nxt = cnt + 1'b1;
                    end else if (bus.SC_SCANCTRL_hold_In) begin
                        // Re-run the lit part of the same slot; no blank since data is unchanged.
                        cnt_nxt = HOLD_CNT;
                    end else begin
                        state_nxt = ST_BLANK;
                        cnt_nxt   = '0;
                        if (sel == SEL_LAST) begin
                            sel_nxt        = '0;
                            frame_done_nxt = 1'b1;
                        end else begin
                            sel_nxt = sel + 4'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    sel_nxt   = '0;
                end
            endcase
        end

        row_nxt = '0;
        oe_nxt  = 1'b0;
        if (state_nxt == ST_SHOW) begin
            oe_nxt  = 1'b1;
            row_nxt = NUM_SRC'(1) << sel_nxt;
        end
    end

    assign bus.SC_SCANCTRL_select_OutBUS = sel;
    assign bus.SC_SCANCTRL_row_OutBUS    = row;
    assign bus.SC_SCANCTRL_oe_Out        = oe;
    assign bus.SC_SCANCTRL_frameDone_Out = frame_done;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: 10-source build (DWELL=8, BLANK=2) plus a
// 4-source build for the select wrap.
`timescale 1ns/1ps
module tb_mux_scan_ctrl;
    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    mux_scan_ctrl_if #(.NUM_SRC(10)) bus ();
    mux_scan_ctrl_if #(.NUM_SRC(4))  bus_s ();

    mux_scan_ctrl #(.NUM_SRC(10), .DWELL(8), .BLANK(2), .CNT_W(4)) dut (
        .SC_SCANCTRL_CLOCK_50   (clk),
        .SC_SCANCTRL_RESET_InLow(rst_n),
        .bus                    (bus)
    );

    mux_scan_ctrl #(.NUM_SRC(4), .DWELL(8), .BLANK(2), .CNT_W(4)) dut_s (
        .SC_SCANCTRL_CLOCK_50   (clk),
        .SC_SCANCTRL_RESET_InLow(rst_n),
        .bus                    (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running want finished");
        $fatal(1);
    end

    // Observed {select,row,oe,frameDone} of the 10-source build.
    function automatic logic [15:0] obs();
        return {bus.SC_SCANCTRL_select_OutBUS, bus.SC_SCANCTRL_row_OutBUS,
                bus.SC_SCANCTRL_oe_Out, bus.SC_SCANCTRL_frameDone_Out};
    endfunction

    task automatic test_reset();
        logic [15:0] exp;
        bus.SC_SCANCTRL_enable_In = 1'b1;
        bus.SC_SCANCTRL_hold_In   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            exp = '0;
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL reset_hold i=%0d got %h want %h", i, obs(), exp);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            exp = {4'd0, (k >= 2) ? 10'd1 : 10'd0, (k >= 2), 1'b0};
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL reset_release k=%0d got %h want %h", k, obs(), exp);
            end
        end
    endtask

    task automatic test_scan();
        logic [15:0] exp;
        logic [3:0]  s;
        logic        o;
        for (int k = 8; k < 80; k++) begin
            @(posedge clk); #1;
            s   = 4'((k / 8) % 10);
            o   = (k % 8) >= 2;
            exp = {s, o ? (10'd1 << s) : 10'd0, o, 1'b0};
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL scan k=%0d got %h want %h", k, obs(), exp);
            end
        end
    endtask

    task automatic test_frame_wrap();
        logic [15:0] exp;
        logic        o;
        for (int k = 80; k < 88; k++) begin
            @(posedge clk); #1;
            o   = (k % 8) >= 2;
            exp = {4'd0, o ? 10'd1 : 10'd0, o, (k == 80)};
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL frame_wrap k=%0d got %h want %h", k, obs(), exp);
            end
        end
    endtask

    task automatic test_hold();
        logic [15:0] exp;
        logic [3:0]  s;
        logic        o;
        repeat (24) @(posedge clk); // up to slot 3, counter 7
        #1;
        exp = {4'd3, 10'd8, 1'b1, 1'b0};
        n_cmp++;
        if (obs() !== exp) begin
            n_bad++;
            $display("FAIL hold_pre got %h want %h", obs(), exp);
        end
        bus.SC_SCANCTRL_hold_In = 1'b1;
        for (int j = 0; j < 14; j++) begin
            @(posedge clk); #1;
            if (j == 0) bus.SC_SCANCTRL_hold_In = 1'b0;
            s   = (j < 6) ? 4'd3 : 4'd4;
            o   = (j < 6) || (j >= 8);
            exp = {s, o ? (10'd1 << s) : 10'd0, o, 1'b0};
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL hold j=%0d got %h want %h", j, obs(), exp);
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [15:0] exp;
        repeat (13) @(posedge clk); // slot 6, counter 4
        #1;
        exp = {4'd6, 10'd64, 1'b1, 1'b0};
        n_cmp++;
        if (obs() !== exp) begin
            n_bad++;
            $display("FAIL drop_pre got %h want %h", obs(), exp);
        end
        bus.SC_SCANCTRL_enable_In = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            exp = '0;
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL drop_idle i=%0d got %h want %h", i, obs(), exp);
            end
        end
        bus.SC_SCANCTRL_enable_In = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            exp = {4'd0, (j >= 2) ? 10'd1 : 10'd0, (j >= 2), 1'b0};
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL drop_restart j=%0d got %h want %h", j, obs(), exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] exp;
        repeat (36) @(posedge clk); // slot 5, counter 3
        #1;
        exp = {4'd5, 10'd32, 1'b1, 1'b0};
        n_cmp++;
        if (obs() !== exp) begin
            n_bad++;
            $display("FAIL areset_pre got %h want %h", obs(), exp);
        end
        #2 rst_n = 1'b0;
        #1;
        exp = '0;
        n_cmp++;
        if (obs() !== exp) begin
            n_bad++;
            $display("FAIL areset_immediate got %h want %h", obs(), exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_small_wrap();
        logic [9:0] exp, got;
        logic [3:0] s;
        logic       o;
        @(posedge clk); #1;
        bus_s.SC_SCANCTRL_enable_In = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            s   = 4'((k / 8) % 4);
            o   = (k % 8) >= 2;
            exp = {s, o ? (4'd1 << s) : 4'd0, o, (k == 32)};
            got = {bus_s.SC_SCANCTRL_select_OutBUS, bus_s.SC_SCANCTRL_row_OutBUS,
                   bus_s.SC_SCANCTRL_oe_Out, bus_s.SC_SCANCTRL_frameDone_Out};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL small_wrap k=%0d got %h want %h", k, got, exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        bus.SC_SCANCTRL_enable_In   = 1'b0;
        bus.SC_SCANCTRL_hold_In     = 1'b0;
        bus_s.SC_SCANCTRL_enable_In = 1'b0;
        bus_s.SC_SCANCTRL_hold_In   = 1'b0;
        #1 rst_n = 1'b0;
        test_reset();
        test_scan();
        test_frame_wrap();
        test_hold();
        test_enable_drop();
        test_async_reset();
        test_small_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer for the 10-way, 8-bit row-data multiplexer that feeds the LED matrix.
- Steps the multiplexer select through sources 0..NUM_SRC-1 at a fixed dwell per slot.
- Inserts a blanking interval at the start of every slot so ghosting is suppressed while select and data settle.
- Drives the one-hot row enables and output-enable, and flags frame boundaries to the game logic.

Parameters:
NUM_SRC, 10, number of multiplexer sources scanned (2..16); select never exceeds NUM_SRC-1
DWELL, 1000, clock cycles per slot, including blanking
BLANK, 16, blanked cycles at start of each slot; constraint 1 <= BLANK < DWELL
CNT_W, 16, dwell counter width; must hold DWELL-1

Ports:
SC_SCANCTRL_CLOCK_50  input  1  system clock, all logic on rising edge
SC_SCANCTRL_RESET_InLow  input  1  asynchronous active-low reset
SC_SCANCTRL_enable_In  input  1  1 = scan running, 0 = idle/blank
SC_SCANCTRL_hold_In  input  1  1 = freeze on current slot at slot end
SC_SCANCTRL_select_OutBUS  output  4  multiplexer select
SC_SCANCTRL_row_OutBUS  output  NUM_SRC  one-hot row enable, active-high; all-zero when blanked
SC_SCANCTRL_oe_Out  output  1  display output enable, 1 only in SHOW
SC_SCANCTRL_frameDone_Out  output  1  one-cycle pulse at frame wrap

Behaviour:
- Reset (async, RESET_InLow=0): state=IDLE, select=0, counter=0, row=0, oe=0, frameDone=0. Release is sampled synchronously; the first active edge after release evaluates IDLE.
- All outputs are registered (Moore). No combinational path from inputs to outputs.
- States: IDLE, BLANK, SHOW.
- IDLE:
  - row=0, oe=0, select=0, counter=0.
  - enable=1 -> BLANK, counter=0.
- BLANK:
  - row=0, oe=0.
  - counter increments each cycle.
  - When counter==BLANK-1: -> SHOW, counter continues (+1).
- SHOW:
  - oe=1, row=one-hot(select).
  - counter increments each cycle.
  - When counter==DWELL-1 and hold=0: counter=0, select advances (NUM_SRC-1 wraps to 0), -> BLANK.
  - When counter==DWELL-1 and hold=1: counter=BLANK, select unchanged, stay in SHOW (no blank; data is unchanged).
- Slot timing: BLANK cycles blanked, then DWELL-BLANK cycles lit. Frame = NUM_SRC*DWELL cycles when hold=0.
- frameDone: asserted for exactly one cycle, the cycle select registers the NUM_SRC-1 -> 0 wrap (first BLANK cycle of slot 0). It never asserts on the initial IDLE->BLANK entry.
- enable=0 in any state: next edge -> IDLE, with select=0, counter=0, row=0, oe=0, frameDone=0. This takes priority over slot-end and hold.
- hold sampled only at counter==DWELL-1 in SHOW; ignored elsewhere.
- row and oe change on the same edge as the state; select changes only on entry to BLANK, so select is stable whenever oe=1.
- Async reset mid-slot: outputs go to reset values immediately, without waiting for a clock edge.

Test Plan:
Use NUM_SRC=10, DWELL=8, BLANK=2 unless noted.
1. Reset low, clocks running, enable=1 -> select=0, row=0, oe=0, frameDone=0 throughout; after release, oe=0 for 2 cycles then oe=1, row=10'b0000000001 for 6 cycles.
2. enable=1, hold=0 for 80 cycles -> select sequence 0,1,...,9 each held 8 cycles; oe pattern 2 low / 6 high per slot; row one-hot matches select while oe=1.
3. Run through wrap -> frameDone=1 for exactly one cycle when select goes 9->0, i.e. every 80 cycles; frameDone=0 on the first frame start after IDLE.
4. hold=1 during slot 3 at counter==7 -> select stays 3, oe stays 1 with no blank cycles; releasing hold resumes 3->4 at the next slot end with a 2-cycle blank.
5. enable dropped mid-SHOW of slot 6 -> next edge select=0, row=0, oe=0, state IDLE; re-asserting enable restarts at slot 0 with the blank.
6. Async reset pulsed between clock edges during slot 5 -> outputs clear immediately without a clock edge; NUM_SRC=4 build shows select wrapping 3->0, never 4.
